bcd_counter_4dig: RTL and testbench
===================================

Name: bcd_counter_4dig

Overview:
Four-decade BCD counter that produces the digit values for the four seven-segment displays HEX3..HEX0. It sits directly upstream of the digit-to-segment decoder: each 4-bit digit output drives one decoder instance. Counting is paced by an internal prescaler tick. The block supports start/stop toggle, up/down direction, parallel load and terminal-count signalling.

Parameters:
TICK_DIV, 50000000, clock cycles per count step (1 Hz at 50 MHz); must be >= 2; bench uses 4.
PRE_W, 26, prescaler width; must satisfy 2**PRE_W >= TICK_DIV.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
start_stop  input  1  level from push-button (already debounced, active-high); rising edge toggles running.
up_dn  input  1  1 = count up, 0 = count down; sampled on the tick cycle.
load  input  1  synchronous parallel load strobe.
load_val  input  16  four BCD nibbles; [15:12] = digit 3 (most significant) ... [3:0] = digit 0.
digit3  output  4  thousands digit, 0..9.
digit2  output  4  hundreds digit, 0..9.
digit1  output  4  tens digit, 0..9.
digit0  output  4  units digit, 0..9.
running  output  1  1 while counting is enabled.
tc  output  1  one-cycle pulse on wrap (9999->0000 up, 0000->9999 down).

Behaviour:
- Reset (rst=1 at a clock edge): digits = 0000, running = 0, prescaler = 0, tc = 0, edge-detect register = 0. rst overrides every other input.
- Edge detect: the start_stop value from the previous cycle is registered as prev.
  - At an edge where start_stop=1 and prev=0, running toggles. It takes its new value on that same edge.
  - Holding start_stop high does not re-toggle.
- Prescaler:
  - Counts only while running=1. At TICK_DIV-1 it wraps to 0 and asserts the internal tick for that cycle.
  - While running=0 the prescaler holds its value and resumes from there when restarted.
  - The first tick after a start comes TICK_DIV cycles after running rises, provided the prescaler was at 0.
- Count step (tick=1, load=0), digits registered, latency 1 cycle from the tick:
  - Up: digit0 increments. Any digit at 9 becomes 0 and carries into the next digit. 9999 -> 0000.
  - Down: digit0 decrements. Any digit at 0 becomes 9 and borrows from the next digit. 0000 -> 9999.
  - tc = 1 in exactly the cycle the wrapped value first appears on the digits; otherwise 0.
- Load (load=1, rst=0):
  - Digits take load_val on the next edge. Any nibble > 9 is clamped to 9.
  - Prescaler is cleared to 0 and tc = 0.
  - Load has priority over a coincident tick; that tick is discarded.
  - running is unaffected; a coincident start edge still toggles running.
- Priority: rst > load > tick. Start/stop toggling is independent of load.
- Digit outputs are always valid BCD (0..9), in every state.
- Reset mid-count clears everything within one edge; no partial carry survives.
- If up_dn changes between ticks, only its value on the tick cycle matters.

Decomposition:
- Package bcd_pkg:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - BCD_MIN = 4'd0
  - N_DIGITS = 4
  - function bcd_clamp (nibble > 9 -> 9)
- Sub-module bcd_digit: one decade register with inputs en, up, load, ld_val and outputs q, carry_out (q==9 and up), borrow_out (q==0 and !up).
  - Instantiated four times, chained so that stage n's enable = tick and all lower-stage carries/borrows.
  - Top level holds the prescaler, edge detect and tc register.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then idle 20 cycles with start_stop=0 -> digits 0000, running=0, tc=0 throughout.
- Count up with TICK_DIV=4: one start_stop pulse, up_dn=1 -> running=1; digits reach 0001 after 4 cycles, 0002 after 8; hold start_stop high 10 cycles -> no extra toggle.
- Up wrap: load 16'h9998, start, up_dn=1 -> 9999, then 0000 with tc=1 for one cycle only; the next tick gives 0001 with tc=0.
- Down wrap and borrow: load 16'h1000, up_dn=0 -> 0999 after one tick; load 16'h0000 -> next tick gives 9999 with tc=1.
- Load clamp and priority: load_val=16'hFA3C with load asserted on a tick cycle -> digits 9939, tick discarded, prescaler restarts (next step 4 cycles later).
- Stop/resume and reset mid-count: stop after 2 prescaler cycles -> digits frozen for 50 cycles; restart -> next step after 2 more cycles; assert rst while running -> digits 0000, running=0 on the next edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD widths, limits and nibble clamp helper
package bcd_pkg;

    localparam int BCD_W    = 4;
    localparam int N_DIGITS = 4;

    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    // Nibbles above 9 are not valid BCD; saturate them to 9.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one up/down decade register with load and carry/borrow out
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   en            step this decade this cycle
//   up            1 = increment, 0 = decrement
//   load, ld_val  parallel load (clamped to 0..9), wins over en
//   q             current decade value, always 0..9
//   carry_out     q==9 while counting up (next step wraps to 0)
//   borrow_out    q==0 while counting down (next step wraps to 9)
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [BCD_W-1:0] ld_val,
    output logic [BCD_W-1:0] q,
    output logic             carry_out,
    output logic             borrow_out
);

    logic [BCD_W-1:0] q_q;
    logic [BCD_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = bcd_clamp(ld_val);
        end else if (en) begin
            if (up) begin
                q_d = (q_q >= BCD_MAX) ? BCD_MIN : q_q + BCD_W'(1);
            end else begin
                q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - BCD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= BCD_MIN;
        end else begin
            q_q <= q_d;
        end
    end

    assign q          = q_q;
    assign carry_out  = up & (q_q == BCD_MAX);
    assign borrow_out = ~up & (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_4dig.sv
// rtl/bcd_counter_4dig.sv - four-decade BCD counter with prescaler, start/stop, load and wrap pulse
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start_stop       debounced button level; each rising edge toggles running
//   up_dn            direction, sampled on the tick cycle (1 = up)
//   load, load_val   parallel load of four BCD nibbles, [15:12] = digit 3
//   digit3..digit0   decade outputs, always 0..9
//   running          counting enabled
//   tc               one-cycle pulse when the count wraps (9999<->0000)
module bcd_counter_4dig
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int PRE_W    = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        up_dn,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic        running,
    output logic        tc
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic             prev_q, prev_d;
    logic             running_q, running_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tc_q, tc_d;

    logic             tick;
    logic             step;

    logic [N_DIGITS-1:0] dig_en;
    logic [N_DIGITS-1:0] dig_carry;
    logic [N_DIGITS-1:0] dig_borrow;
    logic [BCD_W-1:0]    dig_q [N_DIGITS];

    always_comb begin
        logic chain;

        prev_d    = start_stop;
        running_d = running_q ^ (start_stop & ~prev_q);

        tick = running_q & (pre_q == PRE_LAST);
        // A load discards a coincident tick and restarts the prescaler.
        step = tick & ~load;

        pre_d = pre_q;
        if (load) begin
            pre_d = '0;
        end else if (running_q) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
        end

        // Decade n steps only when every lower decade is about to wrap.
        chain = step;
        for (int i = 0; i < N_DIGITS; i++) begin
            dig_en[i] = chain;
            chain     = chain & (dig_carry[i] | dig_borrow[i]);
        end

        // chain is now set only when all four decades wrap together.
        tc_d = chain;
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
        bcd_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .en         (dig_en[g]),
            .up         (up_dn),
            .load       (load),
            .ld_val     (load_val[g*BCD_W +: BCD_W]),
            .q          (dig_q[g]),
            .carry_out  (dig_carry[g]),
            .borrow_out (dig_borrow[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= 1'b0;
            running_q <= 1'b0;
            pre_q     <= '0;
            tc_q      <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            running_q <= running_d;
            pre_q     <= pre_d;
            tc_q      <= tc_d;
        end
    end

    assign digit3  = dig_q[3];
    assign digit2  = dig_q[2];
    assign digit1  = dig_q[1];
    assign digit0  = dig_q[0];
    assign running = running_q;
    assign tc      = tc_q;

endmodule

// File: tb/tb_bcd_counter_4dig.sv
// tb/tb_bcd_counter_4dig.sv - self-checking bench for bcd_counter_4dig
module tb_bcd_counter_4dig;

    localparam int TICK_DIV = 4;
    localparam int PRE_W    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_stop = 1'b0;
    logic        up_dn = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [3:0]  digit3, digit2, digit1, digit0;
    logic        running, tc;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference model: the count is a plain integer 0..9999.
    int m_cnt  = 0;
    int m_pre  = 0;
    bit m_run  = 1'b0;
    bit m_prev = 1'b0;
    bit m_tc   = 1'b0;

    bcd_counter_4dig #(
        .TICK_DIV (TICK_DIV),
        .PRE_W    (PRE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .up_dn      (up_dn),
        .load       (load),
        .load_val   (load_val),
        .digit3     (digit3),
        .digit2     (digit2),
        .digit1     (digit1),
        .digit0     (digit0),
        .running    (running),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    function automatic int load_to_int(input logic [15:0] v);
        int acc = 0;
        int w   = 1;
        for (int k = 0; k < 4; k++) begin
            int nib = int'(v[4*k +: 4]);
            if (nib > 9) nib = 9;
            acc += nib * w;
            w   *= 10;
        end
        return acc;
    endfunction

    function automatic int bcd_to_int(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_pre  <= 0;
            m_run  <= 1'b0;
            m_prev <= 1'b0;
            m_tc   <= 1'b0;
        end else begin
            m_prev <= start_stop;
            m_run  <= m_run ^ (start_stop && !m_prev);
            if (load) begin
                m_cnt <= load_to_int(load_val);
                m_pre <= 0;
                m_tc  <= 1'b0;
            end else if (m_run && m_pre == TICK_DIV - 1) begin
                m_pre <= 0;
                if (up_dn) begin
                    m_cnt <= (m_cnt + 1) % 10000;
                    m_tc  <= (m_cnt == 9999);
                end else begin
                    m_cnt <= (m_cnt + 9999) % 10000;
                    m_tc  <= (m_cnt == 0);
                end
            end else begin
                if (m_run) m_pre <= m_pre + 1;
                m_tc <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (bcd_to_int({digit3, digit2, digit1, digit0}) != m_cnt) begin
                failures++;
                $display("FAIL cyc_digits t=%0t got=%h%h%h%h exp=%04d", $time, digit3, digit2, digit1, digit0, m_cnt);
            end
            checks++;
            if (running !== m_run) begin
                failures++;
                $display("FAIL cyc_running t=%0t got=%b exp=%b", $time, running, m_run);
            end
            checks++;
            if (tc !== m_tc) begin
                failures++;
                $display("FAIL cyc_tc t=%0t got=%b exp=%b", $time, tc, m_tc);
            end
            checks++;
            if (!(digit3 <= 4'd9 && digit2 <= 4'd9 && digit1 <= 4'd9 && digit0 <= 4'd9)) begin
                failures++;
                $display("FAIL cyc_bcd_valid t=%0t got=%h%h%h%h", $time, digit3, digit2, digit1, digit0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_now(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic check_lit(input string name, input logic [15:0] exp_bcd,
                             input logic exp_run, input logic exp_tc);
        logic [15:0] got;
        got = {digit3, digit2, digit1, digit0};
        checks++;
        if (got !== exp_bcd) begin
            failures++;
            $display("FAIL %s digits got=%h exp=%h", name, got, exp_bcd);
        end
        checks++;
        if (running !== exp_run) begin
            failures++;
            $display("FAIL %s running got=%b exp=%b", name, running, exp_run);
        end
        checks++;
        if (tc !== exp_tc) begin
            failures++;
            $display("FAIL %s tc got=%b exp=%b", name, tc, exp_tc);
        end
        checks++;
        if (m_cnt != bcd_to_int(exp_bcd) || m_run != exp_run || m_tc != exp_tc) begin
            failures++;
            $display("FAIL %s model got=%04d/%b/%b exp=%h/%b/%b", name, m_cnt, m_run, m_tc, exp_bcd, exp_run, exp_tc);
        end
    endtask

    initial begin
        // Reset and idle
        cyc(2);
        rst    = 1'b0;
        cmp_en = 1'b1;
        check_lit("reset", 16'h0000, 1'b0, 1'b0);
        cyc(20);
        check_lit("idle", 16'h0000, 1'b0, 1'b0);

        // Count up; start_stop held high 10 cycles
        up_dn      = 1'b1;
        start_stop = 1'b1;
        cyc(1);
        check_lit("start", 16'h0000, 1'b1, 1'b0);
        cyc(3);
        check_lit("pre_tick", 16'h0000, 1'b1, 1'b0);
        cyc(1);
        check_lit("first_step", 16'h0001, 1'b1, 1'b0);
        cyc(4);
        check_lit("second_step", 16'h0002, 1'b1, 1'b0);
        cyc(1);
        check_lit("hold_no_toggle", 16'h0002, 1'b1, 1'b0);
        start_stop = 1'b0;

        // Up wrap
        load_now(16'h9998);
        check_lit("load_9998", 16'h9998, 1'b1, 1'b0);
        cyc(4);
        check_lit("up_9999", 16'h9999, 1'b1, 1'b0);
        cyc(4);
        check_lit("up_wrap", 16'h0000, 1'b1, 1'b1);
        cyc(1);
        check_lit("up_wrap_tc_drop", 16'h0000, 1'b1, 1'b0);
        cyc(3);
        check_lit("up_after_wrap", 16'h0001, 1'b1, 1'b0);

        // Down borrow and wrap
        up_dn = 1'b0;
        load_now(16'h1000);
        cyc(4);
        check_lit("down_borrow", 16'h0999, 1'b1, 1'b0);
        load_now(16'h0000);
        cyc(4);
        check_lit("down_wrap", 16'h9999, 1'b1, 1'b1);
        cyc(1);
        check_lit("down_wrap_tc_drop", 16'h9999, 1'b1, 1'b0);

        // Clamp and load-over-tick priority
        up_dn = 1'b1;
        load_now(16'h1234);
        cyc(3);
        load_now(16'hFA3C);
        check_lit("clamp_load", 16'h9939, 1'b1, 1'b0);
        cyc(3);
        check_lit("clamp_hold", 16'h9939, 1'b1, 1'b0);
        cyc(1);
        check_lit("clamp_next_step", 16'h9940, 1'b1, 1'b0);

        // Direction changes between ticks: only the tick-cycle value matters
        load_now(16'h0500);
        up_dn = 1'b0;
        cyc(2);
        up_dn = 1'b1;
        cyc(2);
        check_lit("dir_tick_sample", 16'h0501, 1'b1, 1'b0);

        // Stop / resume
        load_now(16'h0500);
        cyc(1);
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        check_lit("stopped", 16'h0500, 1'b0, 1'b0);
        cyc(50);
        check_lit("frozen", 16'h0500, 1'b0, 1'b0);
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        check_lit("restart", 16'h0500, 1'b1, 1'b0);
        cyc(1);
        check_lit("resume_wait", 16'h0500, 1'b1, 1'b0);
        cyc(1);
        check_lit("resume_step", 16'h0501, 1'b1, 1'b0);

        // Reset mid-count
        cyc(2);
        rst = 1'b1;
        cyc(1);
        check_lit("mid_reset", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(6);
        check_lit("post_reset_idle", 16'h0000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
